// File: rtl/ahblite_cmd_master.sv
// ahblite_cmd_master
//   AHB-Lite initiator that turns a valid/ready command stream into single NONSEQ transfers.
//   One command sits in the address-phase (AP) slot while the previous one is in the
//   data-phase (DP) slot, so back-to-back commands issue with no idle cycles. A two-cycle
//   ERROR response cancels the pending address phase, which is re-driven afterwards.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_write, cmd_size, cmd_addr, cmd_wdata payload
//   rsp_valid             one-cycle pulse per completed transfer, issue order
//   rsp_err, rsp_rdata    ERROR flag and captured read data (0 for writes and errors)
//   busy                  AP or DP slot occupied
//   timeout_err           sticky data-phase wait-state timeout flag
//   HADDR..HWDATA         registered AHB-Lite master outputs
//   HREADY, HRESP, HRDATA slave response mux inputs
//
// Optional feature: define AHBLITE_CMD_MASTER_TIMEOUT_EN to build the wait-state counter;
// otherwise timeout_err is tied to 0.

module ahblite_cmd_master #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    // Address-phase slot; nonseq_q is low while a held command is cancelled by ERROR
    logic              ap_full_q, ap_full_d;
    logic              nonseq_q, nonseq_d;
    logic              ap_write_q, ap_write_d;
    logic [2:0]        ap_size_q, ap_size_d;
    logic [ADDR_W-1:0] ap_addr_q, ap_addr_d;
    logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
    // Data-phase slot
    logic              dp_full_q, dp_full_d;
    logic              dp_write_q, dp_write_d;
    logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
    // Response registers
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic ap_done, dp_done, err_first, accept;

    assign cmd_ready = !HRESET && (!ap_full_q || (HREADY && !HRESP));

    always_comb begin
        ap_done   = nonseq_q && HREADY && !HRESP;
        dp_done   = dp_full_q && HREADY;
        err_first = dp_full_q && HRESP && !HREADY;
        accept    = cmd_valid && cmd_ready;

        ap_full_d  = ap_full_q;
        ap_write_d = ap_write_q;
        ap_size_d  = ap_size_q;
        ap_addr_d  = ap_addr_q;
        ap_wdata_d = ap_wdata_q;
        dp_full_d  = dp_full_q;
        dp_write_d = dp_write_q;
        dp_wdata_d = dp_wdata_q;

        if (ap_done) begin
            dp_full_d  = 1'b1;
            dp_write_d = ap_write_q;
            dp_wdata_d = ap_wdata_q;
        end else if (dp_done) begin
            dp_full_d = 1'b0;
        end

        // cmd_ready guarantees the AP slot is empty or retiring when a command is accepted
        if (accept) begin
            ap_full_d  = 1'b1;
            ap_write_d = cmd_write;
            ap_size_d  = {1'b0, (cmd_size == 2'd3) ? 2'b10 : cmd_size};
            ap_addr_d  = cmd_addr;
            ap_wdata_d = cmd_wdata;
        end else if (ap_done) begin
            ap_full_d = 1'b0;
        end

        // First ERROR cycle forces IDLE; the held command is re-driven once the error ends
        nonseq_d = ap_full_d && !err_first;

        rsp_valid_d = dp_done;
        rsp_err_d   = dp_done && HRESP;
        rsp_rdata_d = (dp_done && !HRESP && !dp_write_q) ? HRDATA : '0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ap_full_q   <= 1'b0;
            nonseq_q    <= 1'b0;
            ap_write_q  <= 1'b0;
            ap_size_q   <= 3'b010;
            ap_addr_q   <= '0;
            ap_wdata_q  <= '0;
            dp_full_q   <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_wdata_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            ap_full_q   <= ap_full_d;
            nonseq_q    <= nonseq_d;
            ap_write_q  <= ap_write_d;
            ap_size_q   <= ap_size_d;
            ap_addr_q   <= ap_addr_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_full_q   <= dp_full_d;
            dp_write_q  <= dp_write_d;
            dp_wdata_q  <= dp_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign HTRANS    = nonseq_q ? TransNonseq : TransIdle;
    assign HADDR     = ap_addr_q;
    assign HWRITE    = ap_write_q;
    assign HSIZE     = ap_size_q;
    assign HWDATA    = dp_wdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = ap_full_q || dp_full_q;

`ifdef AHBLITE_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] wait_cnt_q;
    logic            timeout_q;

    // Counter saturates at the limit; the flag sets on the edge that reaches it
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (dp_done) begin
            wait_cnt_q <= '0;
        end else if (dp_full_q && !HREADY) begin
            if (wait_cnt_q != CntW'(TIMEOUT_CYCLES)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_q;
`else
    // Limit only matters when the counter is built; keep it referenced
    assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_ahblite_cmd_master.sv
module tb_ahblite_cmd_master;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy, timeout_err;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t sb[$];
    rsp_t exp_rsp;
    int   checks = 0;
    int   errors = 0;

    ahblite_cmd_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .busy(busy), .timeout_err(timeout_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    // Scoreboard: every response pulse must match the oldest expected entry
    always @(negedge HCLK) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 err=%0b rdata=%h, required no response",
                         rsp_err, rsp_rdata);
            end else begin
                exp_rsp = sb.pop_front();
                if (rsp_err !== exp_rsp.err || rsp_rdata !== exp_rsp.rdata) begin
                    errors++;
                    $display("FAIL rsp_content: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             rsp_err, rsp_rdata, exp_rsp.err, exp_rsp.rdata);
                end
            end
        end
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_size  = sz;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic test_reset;
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 2'd2;
        cmd_addr = '0; cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        tick; tick;
        checks += 6;
        if (HTRANS !== IDLE) begin errors++; $display("FAIL rst_htrans: got %b, required %b", HTRANS, IDLE); end
        if (HADDR !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h, required 0", HADDR); end
        if (HSIZE !== 3'b010) begin errors++; $display("FAIL rst_hsize: got %b, required 010", HSIZE); end
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_busy_rsp: got busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
        end
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b, required 0", cmd_ready); end
        if (HPROT !== 4'b0011 || HBURST !== 3'b000 || HMASTLOCK !== 1'b0) begin
            errors++; $display("FAIL rst_fixed: got hprot=%b hburst=%b lock=%b, required 0011 000 0",
                               HPROT, HBURST, HMASTLOCK);
        end
        HRESET = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %b, required 1", cmd_ready); end
        tick;
    endtask

    task automatic test_single_read;
        send(1'b0, 2'd2, 32'h2000_0010, 32'h0);
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        tick;
        cmd_valid = 1'b0;
        checks += 2;
        if (HTRANS !== NONSEQ || HADDR !== 32'h2000_0010) begin
            errors++; $display("FAIL rd_ap: got htrans=%b haddr=%h, required 10 20000010", HTRANS, HADDR);
        end
        if (HWRITE !== 1'b0 || HSIZE !== 3'b010 || busy !== 1'b1) begin
            errors++; $display("FAIL rd_ctrl: got hwrite=%b hsize=%b busy=%b, required 0 010 1",
                               HWRITE, HSIZE, busy);
        end
        tick;
        HRDATA = 32'hDEAD_BEEF;
        checks++;
        if (HTRANS !== IDLE || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_dp: got htrans=%b rsp_valid=%b, required 00 0", HTRANS, rsp_valid);
        end
        tick;
        HRDATA = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_time: got %b, required 1", rsp_valid); end
        tick;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rd_after: got rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h0, 32'h4, 32'h8};
        datas = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 2'd2, addrs[i], datas[i]);
            sb.push_back('{1'b0, 32'h0});
            tick;
            checks++;
            if (HTRANS !== NONSEQ || HADDR !== addrs[i] || HWRITE !== 1'b1) begin
                errors++; $display("FAIL b2b_ap%0d: got htrans=%b haddr=%h hwrite=%b, required 10 %h 1",
                                   i, HTRANS, HADDR, HWRITE, addrs[i]);
            end
            if (i > 0) begin
                checks++;
                if (HWDATA !== datas[i-1]) begin
                    errors++; $display("FAIL b2b_wd%0d: got %h, required %h", i - 1, HWDATA, datas[i-1]);
                end
            end
        end
        cmd_valid = 1'b0;
        tick;
        checks++;
        if (HTRANS !== IDLE || HWDATA !== 32'h33) begin
            errors++; $display("FAIL b2b_tail: got htrans=%b hwdata=%h, required 00 33", HTRANS, HWDATA);
        end
        tick; tick; tick;
    endtask

    task automatic test_hsize;
        logic [1:0] sizes [3];
        logic [2:0] hs    [3];
        sizes = '{2'd0, 2'd1, 2'd3};
        hs    = '{3'b000, 3'b001, 3'b010};
        for (int i = 0; i < 3; i++) begin
            send(1'b0, sizes[i], 32'h40 + 32'(4 * i), 32'h0);
            sb.push_back('{1'b0, 32'h0});
            tick;
            checks++;
            if (HSIZE !== hs[i]) begin
                errors++; $display("FAIL hsize%0d: got %b, required %b", i, HSIZE, hs[i]);
            end
        end
        cmd_valid = 1'b0;
        tick; tick; tick;
    endtask

    task automatic test_wait_states;
        send(1'b0, 2'd2, 32'h100, 32'h0);
        sb.push_back('{1'b0, 32'hCAFE_0001});
        tick;
        send(1'b1, 2'd2, 32'h104, 32'h55);
        sb.push_back('{1'b0, 32'h0});
        tick;
        cmd_valid = 1'b0;
        HREADY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                HREADY = 1'b1;
                HRDATA = 32'hCAFE_0001;
            end
            #1;
            checks++;
            if (HTRANS !== NONSEQ || HADDR !== 32'h104 || HWRITE !== 1'b1 || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL ws_hold%0d: got htrans=%b haddr=%h hwrite=%b rsp_valid=%b, required 10 104 1 0",
                                   i, HTRANS, HADDR, HWRITE, rsp_valid);
            end
            if (i < 3) begin
                checks++;
                if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ws_ready%0d: got %b, required 0", i, cmd_ready); end
            end
            tick;
        end
        HRDATA = 32'h0;
        checks++;
        if (HTRANS !== IDLE || HWDATA !== 32'h55 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL ws_release: got htrans=%b hwdata=%h rsp_valid=%b, required 00 55 1",
                               HTRANS, HWDATA, rsp_valid);
        end
        tick; tick;
    endtask

    task automatic test_error;
        send(1'b1, 2'd2, 32'h4000_0000, 32'h77);
        sb.push_back('{1'b1, 32'h0});
        tick;
        send(1'b0, 2'd2, 32'h50, 32'h0);
        sb.push_back('{1'b0, 32'h1234_5678});
        tick;
        cmd_valid = 1'b0;
        HREADY = 1'b0; HRESP = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL err1_ready: got %b, required 0", cmd_ready); end
        tick;
        HREADY = 1'b1; HRESP = 1'b1;
        #1;
        checks += 2;
        if (HTRANS !== IDLE) begin errors++; $display("FAIL err2_cancel: got htrans=%b, required 00", HTRANS); end
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL err2_ready: got %b, required 0", cmd_ready); end
        tick;
        HRESP = 1'b0;
        checks++;
        if (HTRANS !== NONSEQ || HADDR !== 32'h50 || HWRITE !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL err_reissue: got htrans=%b haddr=%h hwrite=%b rsp_valid=%b, required 10 50 0 1",
                               HTRANS, HADDR, HWRITE, rsp_valid);
        end
        tick;
        HRDATA = 32'h1234_5678;
        tick;
        HRDATA = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL err_rd_rsp: got %b, required 1", rsp_valid); end
        tick;
    endtask

    task automatic test_reset_mid;
        send(1'b0, 2'd2, 32'h300, 32'h0);
        tick;
        cmd_valid = 1'b0;
        tick;
        HREADY = 1'b0;
        tick;
        HRESET = 1'b1;
        tick;
        checks++;
        if (HTRANS !== IDLE || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got htrans=%b rsp_valid=%b busy=%b, required 00 0 0",
                               HTRANS, rsp_valid, busy);
        end
        HRESET = 1'b0;
        HREADY = 1'b1;
        HRDATA = 32'hBAD0_BAD0;
        tick; tick; tick;
        HRDATA = 32'h0;
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after: got busy=%b timeout_err=%b, required 0 0", busy, timeout_err);
        end
    endtask

    task automatic test_timeout;
        logic en;
        logic expv;
`ifdef AHBLITE_CMD_MASTER_TIMEOUT_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        send(1'b1, 2'd2, 32'h600, 32'h99);
        sb.push_back('{1'b0, 32'h0});
        tick;
        cmd_valid = 1'b0;
        tick;
        HREADY = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            expv = en && (i >= 8);
            checks++;
            if (timeout_err !== expv) begin
                errors++; $display("FAIL timeout_wait%0d: got %b, required %b", i, timeout_err, expv);
            end
        end
        HREADY = 1'b1;
        tick;
        checks++;
        if (timeout_err !== en || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL timeout_done: got timeout_err=%b rsp_valid=%b, required %b 1",
                               timeout_err, rsp_valid, en);
        end
        tick; tick;
        checks++;
        if (timeout_err !== en) begin errors++; $display("FAIL timeout_sticky: got %b, required %b", timeout_err, en); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_hsize();
        test_wait_states();
        test_error();
        test_reset_mid();
        test_timeout();
        tick; tick;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d responses outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1);
    end

endmodule
